h80cpu_prefetch: RTL and testbench
==================================

# h80cpu_prefetch

Instruction prefetch queue sitting between the h80 CPU decoder and the h80 bus, directly upstream of the memory slave. It acts as a read-only bus master. It fetches 32-bit words at sequential word-aligned addresses into a small FIFO and hands the decoder one opcode byte per cycle, each tagged with its PC. A flush from the CPU on jump, call, return or interrupt discards the queue and restarts fetching at a new byte address.

## Interface
- BUS_ADDR_WIDTH, 16, bus address width
- BUS_CMD_WIDTH, 3, bus command width; encodings come from h80bus.svh
- BUS_DATA_WIDTH, 32, bus data width
- DEPTH, 4, queue depth in 32-bit words; power of two, ≥2
- clk  input  1  clock; all logic is on the rising edge
- reset_n  input  1  synchronous, active-low reset
- ce_n  output  1  bus chip enable, active low, registered
- addr  output  BUS_ADDR_WIDTH  bus address, always word-aligned ([1:0]=0), registered
- cmd  output  BUS_CMD_WIDTH  bus command, registered
- data_  inout  BUS_DATA_WIDTH  bus data; this block never drives it (always high-Z)
- wait_n  input  1  slave ready; 0 extends the data phase
- flush  input  1  discard queue and refetch from flush_addr
- flush_addr  input  16  byte address of the next instruction
- q_valid  output  1  q_byte/q_pc are valid
- q_byte  output  8  next opcode byte
- q_pc  output  16  byte address of q_byte
- q_pop  input  1  decoder consumes q_byte; ignored when q_valid=0

## Operation
- Bus FSM states:
  - IDLE: ce_n=1, cmd=0.
  - ADDR: ce_n=0, cmd=bus_cmd_read, addr=fetch_addr.
  - DATA: ce_n=0, cmd and addr held.
- FSM transitions:
  - IDLE→ADDR when free slots exist (DEPTH − count − inflight > 0).
  - ADDR→DATA unconditionally.
  - DATA stays in DATA while wait_n=0.
  - DATA with wait_n=1: capture data_ into the queue, fetch_addr += 4 (wraps 0xFFFC→0x0000), then go to ADDR if a slot remains, else IDLE.
- Byte order is little-endian: byte k = data_[8k+7:8k], so byte 0 is at the word address.
- Read side:
  - q_valid = (count>0).
  - q_byte = head word byte[boff].
  - q_pc increments by 1 on each pop, wrapping 0xFFFF→0x0000.
  - A pop at boff=3 retires the head word and sets boff=0.
- Flush, when sampled:
  - count=0, q_valid=0.
  - fetch_addr={flush_addr[15:2],2'b00}, boff=flush_addr[1:0], q_pc=flush_addr.
  - A transaction already in ADDR or DATA always completes on the bus, but is marked stale and its data is dropped. Fetching at the new address starts with the next ADDR.
- Simultaneous events:
  - Flush and pop in the same cycle: flush wins; the pop is ignored.
  - Word capture and head-word retire in the same cycle: both happen; count is unchanged.
  - Capture into a full queue cannot occur, because in-flight transactions are counted when issuing.
- Reset (reset_n=0 at an edge) is equivalent to a flush to 0x0000 with the FSM forced to IDLE:
  - ce_n=1, cmd=0, addr=0, q_valid=0, q_pc=0, boff=0, stale cleared.
  - Reset applied mid-transaction aborts it; ce_n is high in the next cycle.

## Timing
- All bus outputs are registered.
- The slave latches read data at the edge closing ADDR and drives data_ during DATA; this block samples data_ at the edge closing DATA when wait_n=1.
- Flush/reset latency: with flush sampled at edge E0 and the FSM idle, ADDR is the cycle after E0, DATA follows, and q_valid=1 in the cycle after E2, i.e. 2 cycles. If a transaction is in flight, add its remaining cycles.
- Throughput: one word per 2 cycles with zero wait states. The decoder consumes at most 1 byte/cycle, so sustained flow is 2 bytes/cycle fill against ≤1 byte/cycle drain.
- q_valid drops in the cycle after a flush edge.

## Test plan
- Reset release, memory word 0x0000 = 0x44332211, wait_n=1, q_pop=1 continuously -> first ADDR with addr=0x0000 in the cycle after release; q_byte 0x11,0x22,0x33,0x44 with q_pc 0,1,2,3; no bubble after the first word.
- q_pop=0 after reset -> exactly DEPTH reads issued (0x0000…0x000C), then ce_n=1 until a pop retires a word; popping 4 bytes triggers one new read at 0x0010.
- flush with flush_addr=0x1236 while in DATA -> current read completes and is discarded, next addr=0x1234, first q_byte = byte 2 of that word with q_pc=0x1236.
- wait_n held 0 for 3 DATA cycles -> addr/cmd/ce_n stable throughout, exactly one word captured, q_valid delayed by 3 cycles.
- flush_addr=0xFFFE with continuous pop -> q_pc sequence 0xFFFE,0xFFFF,0x0000; second bus read at addr 0x0000.
- reset_n low during ADDR -> ce_n=1 next cycle, q_valid=0; after release, fetching restarts at 0x0000.

Source files
------------

// File: rtl/h80cpu_prefetch.sv
// h80 instruction prefetch queue: a read-only bus master that fills a small word FIFO
// and hands the decoder one opcode byte per cycle, tagged with its PC.
module h80cpu_prefetch #(
    parameter int BUS_ADDR_WIDTH = 16,
    parameter int BUS_CMD_WIDTH  = 3,
    parameter int BUS_DATA_WIDTH = 32,
    parameter int DEPTH          = 4,
    parameter logic [BUS_CMD_WIDTH-1:0] BUS_CMD_READ = {{(BUS_CMD_WIDTH-1){1'b0}}, 1'b1}
) (
    input  logic                      clk,
    input  logic                      reset_n,
    output logic                      ce_n,
    output logic [BUS_ADDR_WIDTH-1:0] addr,
    output logic [BUS_CMD_WIDTH-1:0]  cmd,
    inout  wire  [BUS_DATA_WIDTH-1:0] data_,
    input  logic                      wait_n,
    input  logic                      flush,
    input  logic [15:0]               flush_addr,
    output logic                      q_valid,
    output logic [7:0]                q_byte,
    output logic [15:0]               q_pc,
    input  logic                      q_pop
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    state_t                    state_r, state_s;
    logic [15:0]               fetch_addr_r, fetch_addr_s;
    logic                      stale_r, stale_s;
    logic [CW-1:0]             count_r, count_s;
    logic [PW-1:0]             wr_ptr_r, wr_ptr_s;
    logic [PW-1:0]             rd_ptr_r, rd_ptr_s;
    logic [1:0]                boff_r, boff_s;
    logic [15:0]               q_pc_r, q_pc_s;
    logic [BUS_DATA_WIDTH-1:0] mem_r [DEPTH];
    logic [BUS_DATA_WIDTH-1:0] head_word_s;
    logic                      done_s, capture_s, pop_s, retire_s;

    // Queue bookkeeping and bus FSM next state. A stale transaction is one issued
    // before a flush; it still runs to completion but is never captured or counted.
    always_comb begin
        state_s      = state_r;
        fetch_addr_s = fetch_addr_r;
        stale_s      = stale_r;
        count_s      = count_r;
        wr_ptr_s     = wr_ptr_r;
        rd_ptr_s     = rd_ptr_r;
        boff_s       = boff_r;
        q_pc_s       = q_pc_r;
        done_s       = (state_r == ST_DATA) && wait_n;
        capture_s    = done_s && !stale_r && !flush;
        pop_s        = q_pop && (count_r != {CW{1'b0}}) && !flush;
        retire_s     = pop_s && (boff_r == 2'd3);

        if (flush) begin
            count_s      = {CW{1'b0}};
            wr_ptr_s     = {PW{1'b0}};
            rd_ptr_s     = {PW{1'b0}};
            boff_s       = flush_addr[1:0];
            q_pc_s       = flush_addr;
            fetch_addr_s = {flush_addr[15:2], 2'b00};
        end else begin
            if (pop_s) begin
                q_pc_s = q_pc_r + 16'd1;
                boff_s = boff_r + 2'd1;
            end else begin
                q_pc_s = q_pc_r;
            end
            if (retire_s) begin
                rd_ptr_s = rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_s = rd_ptr_r;
            end
            if (capture_s) begin
                wr_ptr_s     = wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
                fetch_addr_s = fetch_addr_r + 16'd4;
            end else begin
                wr_ptr_s = wr_ptr_r;
            end
            case ({capture_s, retire_s})
                2'b10:   count_s = count_r + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   count_s = count_r - {{(CW-1){1'b0}}, 1'b1};
                default: count_s = count_r;
            endcase
        end

        // Only one transaction is ever in flight, and it is not yet in count_s,
        // so a free slot for the next issue is simply count_s < DEPTH.
        case (state_r)
            ST_IDLE: begin
                if (count_s < CW'(DEPTH)) begin
                    state_s = ST_ADDR;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ADDR: begin
                state_s = ST_DATA;
                if (flush) begin
                    stale_s = 1'b1;
                end else begin
                    stale_s = stale_r;
                end
            end
            ST_DATA: begin
                if (wait_n) begin
                    stale_s = 1'b0;
                    if (count_s < CW'(DEPTH)) begin
                        state_s = ST_ADDR;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end else begin
                    state_s = ST_DATA;
                    if (flush) begin
                        stale_s = 1'b1;
                    end else begin
                        stale_s = stale_r;
                    end
                end
            end
            default: begin
                state_s = ST_IDLE;
                stale_s = 1'b0;
            end
        endcase
    end

    // State and registered bus outputs; reset behaves as a flush to 0x0000 with the FSM idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r      <= ST_IDLE;
            fetch_addr_r <= 16'h0000;
            stale_r      <= 1'b0;
            count_r      <= {CW{1'b0}};
            wr_ptr_r     <= {PW{1'b0}};
            rd_ptr_r     <= {PW{1'b0}};
            boff_r       <= 2'd0;
            q_pc_r       <= 16'h0000;
            ce_n         <= 1'b1;
            cmd          <= {BUS_CMD_WIDTH{1'b0}};
            addr         <= {BUS_ADDR_WIDTH{1'b0}};
        end else begin
            state_r      <= state_s;
            fetch_addr_r <= fetch_addr_s;
            stale_r      <= stale_s;
            count_r      <= count_s;
            wr_ptr_r     <= wr_ptr_s;
            rd_ptr_r     <= rd_ptr_s;
            boff_r       <= boff_s;
            q_pc_r       <= q_pc_s;
            ce_n         <= (state_s == ST_IDLE);
            cmd          <= (state_s == ST_IDLE) ? {BUS_CMD_WIDTH{1'b0}} : BUS_CMD_READ;
            if (state_s == ST_ADDR) begin
                addr <= BUS_ADDR_WIDTH'(fetch_addr_s);
            end
        end
    end

    // Word storage; contents are only meaningful below count_r, so no reset is needed.
    always_ff @(posedge clk) begin
        if (capture_s) begin
            mem_r[wr_ptr_r] <= data_;
        end
    end

    assign head_word_s = mem_r[rd_ptr_r];
    assign q_valid     = (count_r != {CW{1'b0}});
    assign q_byte      = head_word_s[{boff_r, 3'b000} +: 8];
    assign q_pc        = q_pc_r;

endmodule

// File: tb/tb_h80cpu_prefetch.sv
// Directed bench for h80cpu_prefetch: table-driven startup vectors plus hand-written
// sequences for fill/stall, flush, wait states, address wrap and reset mid-transaction.
module tb_h80cpu_prefetch;

    localparam logic [2:0] RD = 3'd1;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic        wait_n     = 1'b1;
    logic        flush      = 1'b0;
    logic [15:0] flush_addr = 16'h0000;
    logic        q_pop      = 1'b0;
    wire         ce_n;
    wire  [15:0] addr;
    wire  [2:0]  cmd;
    wire  [31:0] data_bus;
    wire         q_valid;
    wire  [7:0]  q_byte;
    wire  [15:0] q_pc;

    logic [31:0] slave_data = 32'h0;
    logic        phase      = 1'b0;
    logic [15:0] rd_log [64];
    int          nreads     = 0;
    int          checks     = 0;
    int          errors     = 0;

    assign data_bus = slave_data;

    always #5 clk = ~clk;

    h80cpu_prefetch dut (
        .clk(clk), .reset_n(reset_n), .ce_n(ce_n), .addr(addr), .cmd(cmd),
        .data_(data_bus), .wait_n(wait_n), .flush(flush), .flush_addr(flush_addr),
        .q_valid(q_valid), .q_byte(q_byte), .q_pc(q_pc), .q_pop(q_pop)
    );

    function automatic logic [7:0] mb(input logic [15:0] p);
        logic [7:0] k;
        k = {6'd0, p[1:0]} + 8'd1;
        if (p < 16'd4) return 8'h11 * k;
        return p[7:0] ^ p[15:8] ^ 8'h3C;
    endfunction

    function automatic logic [31:0] mem_word(input logic [15:0] a);
        return {mb(a + 16'd3), mb(a + 16'd2), mb(a + 16'd1), mb(a)};
    endfunction

    // Memory slave: latches the word at the edge closing ADDR, drives it through DATA.
    always @(posedge clk) begin
        if (!reset_n) begin
            phase <= 1'b0;
        end else if (!phase) begin
            if (!ce_n) begin
                phase              <= 1'b1;
                slave_data         <= mem_word(addr);
                rd_log[nreads % 64] <= addr;
                nreads             <= nreads + 1;
            end
        end else if (wait_n) begin
            phase <= 1'b0;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        logic        rst;
        logic        pop;
        logic        ce_n;
        logic [2:0]  cmd;
        logic [15:0] addr;
        logic        qv;
        logic [7:0]  qb;
        logic [15:0] pc;
    } vec_t;

    vec_t vt [14];
    int   base;
    int   got;
    logic [15:0] a0;
    logic [15:0] pcs [3];
    logic [7:0]  bys [3];

    initial begin
        // Startup with continuous pop: reset, first word, then pipelined fill.
        vt[0] = '{1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 8'h00, 16'h0000};
        vt[1] = '{1'b0, 1'b1, 1'b1, 3'd0, 16'h0000, 1'b0, 8'h00, 16'h0000};
        vt[2] = '{1'b1, 1'b1, 1'b0, RD,   16'h0000, 1'b0, 8'h00, 16'h0000};
        vt[3] = '{1'b1, 1'b1, 1'b0, RD,   16'h0000, 1'b0, 8'h00, 16'h0000};
        for (int r = 4; r < 14; r++) begin
            vt[r] = '{1'b1, 1'b1, 1'b0, RD, 16'(4 * ((r - 2) / 2)), 1'b1,
                      mb(16'(r - 4)), 16'(r - 4)};
        end

        @(negedge clk);
        for (int r = 0; r < 14; r++) begin
            reset_n = vt[r].rst;
            q_pop   = vt[r].pop;
            tick();
            chk($sformatf("t1_ce_n[%0d]", r), {31'd0, ce_n}, {31'd0, vt[r].ce_n});
            chk($sformatf("t1_cmd[%0d]", r), {29'd0, cmd}, {29'd0, vt[r].cmd});
            chk($sformatf("t1_addr[%0d]", r), {16'd0, addr}, {16'd0, vt[r].addr});
            chk($sformatf("t1_qv[%0d]", r), {31'd0, q_valid}, {31'd0, vt[r].qv});
            chk($sformatf("t1_pc[%0d]", r), {16'd0, q_pc}, {16'd0, vt[r].pc});
            if (vt[r].qv) chk($sformatf("t1_byte[%0d]", r), {24'd0, q_byte}, {24'd0, vt[r].qb});
        end

        // No pops: exactly DEPTH reads, then idle until a word retires.
        q_pop = 1'b0; reset_n = 1'b0;
        tick(); tick();
        base = nreads; reset_n = 1'b1;
        repeat (15) tick();
        chk("t2_nreads", nreads - base, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("t2_addr[%0d]", k), {16'd0, rd_log[(base + k) % 64]}, 32'(4 * k));
        chk("t2_idle_ce_n", {31'd0, ce_n}, 32'd1);
        chk("t2_qv", {31'd0, q_valid}, 32'd1);
        q_pop = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t2_pc[%0d]", k), {16'd0, q_pc}, 32'(k));
            chk($sformatf("t2_byte[%0d]", k), {24'd0, q_byte}, {24'd0, mb(16'(k))});
            chk($sformatf("t2_hold[%0d]", k), nreads - base, 4);
            tick();
        end
        q_pop = 1'b0;
        chk("t2_reissue_ce_n", {31'd0, ce_n}, 32'd0);
        chk("t2_reissue_addr", {16'd0, addr}, 32'h10);
        tick();
        chk("t2_nreads_after", nreads - base, 5);
        chk("t2_pc_after", {16'd0, q_pc}, 32'd4);

        // Flush during a stalled DATA phase: read completes, data dropped.
        for (int k = 0; k < 20 && !(phase && !ce_n); k++) tick();
        chk("t3_in_data", {31'd0, phase && !ce_n}, 32'd1);
        a0 = addr;
        wait_n = 1'b0; flush = 1'b1; flush_addr = 16'h1236;
        tick();
        flush = 1'b0;
        chk("t3_qv_drop", {31'd0, q_valid}, 32'd0);
        chk("t3_addr_held", {16'd0, addr}, {16'd0, a0});
        chk("t3_ce_held", {31'd0, ce_n}, 32'd0);
        chk("t3_pc", {16'd0, q_pc}, 32'h1236);
        wait_n = 1'b1;
        tick();
        chk("t3_stale_dropped", {31'd0, q_valid}, 32'd0);
        chk("t3_new_addr", {16'd0, addr}, 32'h1234);
        chk("t3_new_ce", {31'd0, ce_n}, 32'd0);
        tick(); tick();
        chk("t3_qv", {31'd0, q_valid}, 32'd1);
        chk("t3_byte", {24'd0, q_byte}, {24'd0, mb(16'h1236)});
        chk("t3_pc2", {16'd0, q_pc}, 32'h1236);
        q_pop = 1'b1; tick(); q_pop = 1'b0;
        chk("t3_byte_next", {24'd0, q_byte}, {24'd0, mb(16'h1237)});
        chk("t3_pc_next", {16'd0, q_pc}, 32'h1237);

        // Three wait states on the first read after reset.
        reset_n = 1'b0;
        tick(); tick();
        base = nreads; wait_n = 1'b0; reset_n = 1'b1;
        tick();
        chk("t4_addr_phase", {31'd0, ce_n}, 32'd0);
        tick();
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("t4_ce_n[%0d]", k), {31'd0, ce_n}, 32'd0);
            chk($sformatf("t4_cmd[%0d]", k), {29'd0, cmd}, {29'd0, RD});
            chk($sformatf("t4_addr[%0d]", k), {16'd0, addr}, 32'd0);
            chk($sformatf("t4_qv[%0d]", k), {31'd0, q_valid}, 32'd0);
            if (k == 3) wait_n = 1'b1;
            tick();
        end
        chk("t4_qv_after", {31'd0, q_valid}, 32'd1);
        chk("t4_byte", {24'd0, q_byte}, 32'h11);
        chk("t4_next_addr", {16'd0, addr}, 32'd4);
        chk("t4_one_read", nreads - base, 1);

        // Flush to 0xFFFE with continuous pop: PC and fetch address wrap.
        repeat (12) tick();
        flush = 1'b1; flush_addr = 16'hFFFE; q_pop = 1'b1;
        tick();
        flush = 1'b0;
        base = nreads;
        chk("t5_qv_drop", {31'd0, q_valid}, 32'd0);
        chk("t5_pc", {16'd0, q_pc}, 32'hFFFE);
        chk("t5_addr", {16'd0, addr}, 32'hFFFC);
        got = 0;
        for (int k = 0; k < 12 && got < 3; k++) begin
            if (q_valid) begin
                pcs[got] = q_pc;
                bys[got] = q_byte;
                got++;
            end
            tick();
        end
        q_pop = 1'b0;
        chk("t5_count", got, 3);
        chk("t5_pc0", {16'd0, pcs[0]}, 32'hFFFE);
        chk("t5_pc1", {16'd0, pcs[1]}, 32'hFFFF);
        chk("t5_pc2", {16'd0, pcs[2]}, 32'h0000);
        chk("t5_b0", {24'd0, bys[0]}, {24'd0, mb(16'hFFFE)});
        chk("t5_b2", {24'd0, bys[2]}, 32'h11);
        chk("t5_rd0", {16'd0, rd_log[base % 64]}, 32'hFFFC);
        chk("t5_rd1", {16'd0, rd_log[(base + 1) % 64]}, 32'h0000);

        // Reset during ADDR aborts the transaction; fetching restarts at 0x0000.
        flush = 1'b1; flush_addr = 16'h0100;
        tick();
        flush = 1'b0;
        chk("t6_in_addr", {31'd0, !ce_n && !phase}, 32'd1);
        chk("t6_addr", {16'd0, addr}, 32'h0100);
        reset_n = 1'b0;
        tick();
        chk("t6_ce_n", {31'd0, ce_n}, 32'd1);
        chk("t6_cmd", {29'd0, cmd}, 32'd0);
        chk("t6_addr_rst", {16'd0, addr}, 32'd0);
        chk("t6_qv", {31'd0, q_valid}, 32'd0);
        chk("t6_pc", {16'd0, q_pc}, 32'd0);
        reset_n = 1'b1;
        tick();
        chk("t6_restart_ce", {31'd0, ce_n}, 32'd0);
        chk("t6_restart_addr", {16'd0, addr}, 32'd0);
        tick(); tick();
        chk("t6_qv_after", {31'd0, q_valid}, 32'd1);
        chk("t6_byte", {24'd0, q_byte}, 32'h11);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
